stall_flush_ctrl: RTL

STALL_FLUSH_CTRL -- requirements
Module: stall_flush_ctrl

---
 rtl/stall_flush_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/stall_flush_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, branch flushes and mul/div stalls with a watchdog.
// Optional performance counters are compiled in when HAZ_PERF_CNT_EN is defined.
module stall_flush_ctrl #(
    parameter int unsigned MD_TIMEOUT_CYC = 40
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        bubble_i,
    input  logic        branch_taken_i,
    input  logic        md_busy_i,
    output logic        pc_write_o,
    output logic        ifid_write_o,
    output logic        ifid_flush_o,
    output logic        idex_write_o,
    output logic        idex_nop_o,
    output logic        exmem_nop_o,
    output logic        md_timeout_o
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LD_STALL,
        ST_MD_WAIT
    } state_e;

    state_e     state_q, state_d;
    logic [5:0] wait_cnt_q, wait_cnt_d;
    logic       md_timeout_q;
    logic       timeout_set;

    // NOTE: every output gets its idle value first so no branch leaves one unassigned (no latch).
    always_comb begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        ifid_flush_o = 1'b0;
        idex_write_o = 1'b1;
        idex_nop_o   = 1'b0;
        exmem_nop_o  = 1'b0;
        state_d      = ST_RUN;

        if (reset_i) begin
            // Freeze the front end and squash everything in flight while reset is held.
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            ifid_flush_o = 1'b1;
            idex_write_o = 1'b0;
            idex_nop_o   = 1'b1;
            exmem_nop_o  = 1'b1;
        end else if (md_busy_i) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            idex_write_o = 1'b0;
            exmem_nop_o  = 1'b1;
            state_d      = ST_MD_WAIT;
        end else if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
            idex_nop_o   = 1'b1;
        end else if (bubble_i && state_q == ST_RUN) begin
            // Only RUN honours a bubble, so each load-use pair costs exactly one cycle.
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            idex_nop_o   = 1'b1;
            state_d      = ST_LD_STALL;
        end
    end

    always_comb begin
        wait_cnt_d = 6'd0;
        if (md_busy_i) begin
            wait_cnt_d = (wait_cnt_q == 6'd63) ? 6'd63 : wait_cnt_q + 6'd1;
        end
    end

    assign timeout_set  = md_busy_i && (32'(wait_cnt_d) == MD_TIMEOUT_CYC);
    assign md_timeout_o = md_timeout_q;

    // NOTE: registered state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_RUN;
            wait_cnt_q   <= 6'd0;
            md_timeout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (timeout_set) begin
                md_timeout_q <= 1'b1;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (!pc_write_o) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (ifid_flush_o) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
